// File: rtl/codix_risc_port_capture_pkg.sv
// Shared types for the codix_risc output-port capture buffer.
// Optional timestamping is enabled by defining CODIX_RISC_PORT_CAPTURE_TS_EN.
package codix_risc_port_capture_pkg;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_e;

  localparam int DROP_CNT_W = 16;

  // Channel-index width, never narrower than one bit.
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Stored entry width: data, plus the timestamp when it is built.
  function automatic int entry_w(input int data_w, input int ts_w);
`ifdef CODIX_RISC_PORT_CAPTURE_TS_EN
    return data_w + ts_w;
`else
    return data_w + 0 * ts_w;
`endif
  endfunction

endpackage

// File: rtl/codix_risc_port_fifo.sv
// Single-clock synchronous FIFO; push into a full FIFO is accepted
// when a pop happens in the same cycle.
module codix_risc_port_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         last
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign last    = (cnt == (AW+1)'(1));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/codix_risc_port_capture.sv
// Multi-channel output-port capture with fixed-priority valid/ready readout.
// Define CODIX_RISC_PORT_CAPTURE_TS_EN to store and present per-entry timestamps.
module codix_risc_port_capture
  import codix_risc_port_capture_pkg::*;
#(
  parameter int CH_NUM = 2,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ERR_W  = 32,
  parameter int TS_W   = 32,
  localparam int CH_W  = chan_w(CH_NUM)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CH_NUM*DATA_W-1:0] port_out,
  input  logic [CH_NUM-1:0]        port_out_en,
  input  logic                     halt,
  input  logic [ERR_W-1:0]         error,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_W-1:0]        rd_data,
  output logic [CH_W-1:0]          rd_ch,
  output logic [TS_W-1:0]          rd_time,
  output logic [CH_NUM-1:0]        ovf,
  output logic [DROP_CNT_W-1:0]    drop_cnt,
  output logic [ERR_W-1:0]         err_q,
  output logic                     done
);
  localparam int EW = entry_w(DATA_W, TS_W);

  typedef struct packed {
    logic [DATA_W-1:0] data;
`ifdef CODIX_RISC_PORT_CAPTURE_TS_EN
    logic [TS_W-1:0]   ts;
`endif
  } entry_t;

  state_e                  state;
  entry_t [CH_NUM-1:0]     din, dout;
  entry_t                  head;
  logic [CH_NUM-1:0]       push, pop, full, empty, last, drop;
  logic [CH_W-1:0]         sel, sel_q;
  logic                    lock_q, any;
  logic [3:0]              ndrop;
  logic [DROP_CNT_W:0]     drop_sum;
  logic                    drain_empty;

`ifdef CODIX_RISC_PORT_CAPTURE_TS_EN
  logic [TS_W-1:0] ts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts <= '0;
    else        ts <= ts + 1'b1;
  end
`endif

  always_comb begin
    din = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      din[i].data = port_out[i*DATA_W +: DATA_W];
`ifdef CODIX_RISC_PORT_CAPTURE_TS_EN
      din[i].ts   = ts;
`endif
    end
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    assign push[i] = (state == ST_RUN) & port_out_en[i];
    assign pop[i]  = rd_valid & rd_ready & (sel == CH_W'(i));
    assign drop[i] = push[i] & full[i] & ~pop[i];

    codix_risc_port_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (din[i]),
      .dout  (dout[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .last  (last[i])
    );
  end

  // A stalled presentation is locked so a newly filled lower channel cannot
  // steal the read port until the current entry is accepted.
  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (!empty[i]) begin
        sel = CH_W'(i);
        any = 1'b1;
      end
    end
    if (lock_q) sel = sel_q;
    rd_valid = lock_q | any;
  end

  assign head    = dout[sel];
  assign rd_data = rd_valid ? head.data : '0;
  assign rd_ch   = rd_valid ? sel : '0;
`ifdef CODIX_RISC_PORT_CAPTURE_TS_EN
  assign rd_time = rd_valid ? head.ts : '0;
`else
  assign rd_time = '0;
`endif

  always_comb begin
    ndrop = '0;
    for (int i = 0; i < CH_NUM; i++) ndrop = ndrop + 4'(drop[i]);
  end

  assign drop_sum    = {1'b0, drop_cnt} + (DROP_CNT_W+1)'(ndrop);
  // No pushes outside RUN, so "empty after this cycle's pop" is exact here.
  assign drain_empty = &(empty | (last & pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      err_q    <= '0;
      done     <= 1'b0;
      ovf      <= '0;
      drop_cnt <= '0;
      lock_q   <= 1'b0;
      sel_q    <= '0;
    end else begin
      lock_q   <= rd_valid & ~rd_ready;
      sel_q    <= sel;
      ovf      <= ovf | drop;
      drop_cnt <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
      case (state)
        ST_RUN: if (halt) begin
          state <= ST_DRAIN;
          err_q <= error;
        end
        ST_DRAIN: if (drain_empty) begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/codix_risc_port_capture.md
# codix_risc_port_capture

Parametrised multi-channel capture buffer for the codix_risc platform's output ports; the synthesizable counterpart of the golden model's port_out/port_out_en/halt/error accessors. Each channel's data is sampled on its enable strobe into a per-channel FIFO, optionally timestamped, and drained through a single valid/ready read port with fixed-priority channel arbitration. Halt freezes capture, latches the error word and signals completion once all FIFOs are drained. Sits between the core's output ports and the testbench/host readout logic.

## Interface
- CH_NUM, 2, number of captured output channels (1..8)
- DATA_W, 32, width of each channel's port_out
- DEPTH, 16, entries per channel FIFO (power of two, >= 2)
- ERR_W, 32, width of the error port
- TS_W, 32, timestamp counter width (used only with the timestamp feature)
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  asynchronous active-low reset
- port_out  in  CH_NUM*DATA_W  channel data, channel i at [i*DATA_W +: DATA_W]
- port_out_en  in  CH_NUM  per-channel write strobe
- halt  in  1  core halt level
- error  in  ERR_W  core error word
- rd_valid  out  1  an entry is presented
- rd_ready  in  1  consumer accepts entry
- rd_data  out  DATA_W  entry data
- rd_ch  out  $clog2(CH_NUM) (min 1)  source channel
- rd_time  out  TS_W  entry timestamp
- ovf  out  CH_NUM  sticky per-channel overflow
- drop_cnt  out  16  total dropped samples, saturating at 0xFFFF
- err_q  out  ERR_W  error word latched at halt
- done  out  1  halted and all FIFOs empty

## Operation
- Reset (RST low): all FIFOs empty, state RUN; rd_valid, rd_data, rd_ch, rd_time, ovf, drop_cnt, err_q, done all 0; timestamp counter 0.
- States: RUN -> DRAIN on first cycle halt=1; DRAIN -> DONE when all FIFOs empty and no read in flight; DONE is terminal until reset. halt deasserting does not leave DRAIN/DONE.
- RUN: for each channel with port_out_en[i]=1, push port_out slice (and current timestamp). Cycle halt first asserts still captures that cycle's strobes; DRAIN/DONE ignore all strobes (not counted as drops).
- err_q loads error on the RUN->DRAIN cycle; held thereafter.
- Full FIFO with strobe and no same-cycle pop of that channel: sample dropped, ovf[i] set (sticky), drop_cnt += number of channels dropping that cycle, saturating.
- Full FIFO with strobe and same-cycle pop of that channel: push accepted, no overflow.
- Arbitration: rd_* present head of lowest-index non-empty channel; selection only changes after a handshake (rd_valid & rd_ready) or when no entry is presented, so presented data stays stable while rd_valid=1 and rd_ready=0.
- Timestamp counter increments every cycle from reset, wraps modulo 2^TS_W.
- done = 1 in DONE only.

## Timing
- Push at cycle N -> entry eligible on rd_* at N+1 (registered outputs, no bypass).
- Handshake at cycle N pops; next entry (same or other channel) presented at N+1; back-to-back reads sustain one entry per cycle.
- rd_time = counter value in the cycle the strobe was sampled.
- halt at N: state DRAIN at N+1, err_q valid at N+1; done rises the cycle after the last pop empties all FIFOs (or N+2 if already empty).
- ovf/drop_cnt update one cycle after the dropping strobe.

## Configuration
- CODIX_RISC_PORT_CAPTURE_TS_EN defined: timestamp counter built, TS_W bits stored per FIFO entry, rd_time driven.
- Not defined: counter and storage removed, rd_time tied to 0, TS_W ignored; all other behaviour identical.

## Structure
- Shared package codix_risc_port_capture_pkg: state enum (RUN, DRAIN, DONE), DROP_CNT_W = 16, entry struct typedef helper for {data, time}.
- One sub-module codix_risc_port_fifo: single-clock synchronous FIFO, parametrised width/depth, push/pop/full/empty, simultaneous push+pop when full allowed; instantiated CH_NUM times.

## Test plan
- Single sample: CH_NUM=2, ch0 strobe data 0xDEADBEEF at cycle 10, rd_ready=1 -> rd_valid at 11, rd_data 0xDEADBEEF, rd_ch 0, rd_time 10 (TS_EN).
- Priority: both channels strobe 0x11/0x22 same cycle, rd_ready=1 -> 0x11 (ch0) then 0x22 (ch1) on consecutive cycles.
- Overflow: DEPTH=4, rd_ready=0, ch1 strobes 6 times -> 4 entries retained, ovf=2'b10, drop_cnt=2; full+pop same cycle with strobe -> no further drop.
- Stall: rd_ready=0 for 5 cycles with entry presented -> rd_data/rd_ch/rd_time stable, rd_valid held.
- Halt: halt with error=0x5 and 3 queued entries, strobes after halt -> err_q=0x5, post-halt strobes ignored, 3 entries drained, done=1 cycle after last pop.
- Reset mid-drain: RST low during DRAIN with 2 entries queued -> all outputs 0, FIFOs empty, state RUN, new strobe captured normally afterwards.
